// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and datapath-control encodings for the multicycle MIPS core
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_R_EXEC    = 4'd3,
        S_R_WB      = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // Moore decode; pc_write_cond marks the branch state, the zero/bne qualification is applied outside.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: c.alu_src_b = SRCB_IMM_SH;
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALUOP_SUB;
                c.pc_source     = PCSRC_ALUOUT;
                c.pc_write_cond = 1'b1;
            end
            S_ADDI_WB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            S_ILLEGAL: c.illegal_op = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - IR/flag inputs and datapath control outputs of the multicycle control unit
interface mc_control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSourceA;
    logic [1:0] AluSourceB;
    logic [1:0] AluOP;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, AluSourceA, AluSourceB, AluOP, PCSource,
               illegal_op, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, AluSourceA, AluSourceB, AluOP, PCSource,
               illegal_op, state_dbg
    );
endinterface

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - datapath-side ALU control decode from AluOP and the R-type funct field
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - Moore FSM sequencing the multicycle MIPS datapath with memory wait-states
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                clock,
    input  logic                r_l,
    mc_control_unit_if.master   bus
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   is_bne_q, is_bne_d;
    logic   is_store_q, is_store_d;
    logic   mem_done;
    logic   fetch_hold;

    assign mem_done   = !MEM_HANDSHAKE || bus.mem_ready;
    assign fetch_hold = (state_q == S_FETCH) && !mem_done;

    always_comb begin
        state_d    = state_q;
        is_bne_d   = is_bne_q;
        is_store_d = is_store_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                is_bne_d   = (bus.opcode == OP_BNE);
                is_store_d = (bus.opcode == OP_SW);
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_done) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_done) state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_R_WB, S_MEM_WB, S_BRANCH, S_ADDI_WB, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
            default:     state_d = S_RESET;
        endcase
        // Outputs are registered alongside the state so they always match state_q.
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clock) begin
        if (r_l) begin
            state_q    <= S_RESET;
            ctrl_q     <= '0;
            is_bne_q   <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            is_bne_q   <= is_bne_d;
            is_store_q <= is_store_d;
        end
    end

    // Strobes are masked by r_l so a memory access aborted by reset releases the bus at once.
    assign bus.MemRead     = ctrl_q.mem_read  && !r_l;
    assign bus.MemWrite    = ctrl_q.mem_write && !r_l;
    assign bus.PCWrite     = ctrl_q.pc_write  && !fetch_hold;
    assign bus.IRWrite     = ctrl_q.ir_write  && !fetch_hold;
    assign bus.PCWriteCond = ctrl_q.pc_write_cond && (bus.zero ^ is_bne_q);
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.AluSourceA  = ctrl_q.alu_src_a;
    assign bus.AluSourceB  = ctrl_q.alu_src_b;
    assign bus.AluOP       = ctrl_q.alu_op;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.illegal_op  = ctrl_q.illegal_op;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed and randomized checks of mc_control_unit against a per-cycle instruction model
module tb_mc_control_unit;
    import ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       r_l;
    logic [3:0] alu_ctrl;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    mc_control_unit_if bus();

    mc_control_unit #(.MEM_HANDSHAKE(1'b1)) dut (
        .clock (clock),
        .r_l   (r_l),
        .bus   (bus)
    );

    alu_op_decode u_alu_dec (
        .alu_op   (bus.AluOP),
        .funct    (bus.funct),
        .alu_ctrl (alu_ctrl)
    );

    function automatic logic [16:0] v(input bit pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
                                      input bit [1:0] sb, aop, ps, input bit ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.AluSourceA, bus.AluSourceB,
                bus.AluOP, bus.PCSource, bus.illegal_op};
    endfunction

    function automatic logic [3:0] funct_to_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, compare at the falling edge, advance past the rising edge.
    task automatic step(input logic [16:0] e, input logic rdy, input string tag,
                        input int exp_alu, input bit exp_fetch);
        bus.mem_ready = rdy;
        @(negedge clock);
        check(tag, observed(), e);
        check({tag, "_mem_excl"}, bus.MemRead & bus.MemWrite, 0);
        if (exp_alu >= 0) check({tag, "_alu_ctrl"}, alu_ctrl, exp_alu);
        if (exp_fetch) check({tag, "_state"}, bus.state_dbg, S_FETCH);
        @(posedge clock);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Walks one instruction from FETCH through its final state, building each cycle's outputs from the op's step list.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        logic [16:0] f_wait, f_go, dec, mem_addr;
        f_wait   = v(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        f_go     = v(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        dec      = v(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        mem_addr = v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int i = 0; i < fw; i++) step(f_wait, 1'b0, "fetch_wait", -1, i == 0);
        step(f_go, 1'b1, "fetch", -1, fw == 0);
        step(dec, rnd(), "decode", -1, 1'b0);
        case (op)
            6'h00: begin
                step(v(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), rnd(), "r_exec", int'(funct_to_alu(fn)), 1'b0);
                step(v(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), rnd(), "r_wb", -1, 1'b0);
            end
            6'h23: begin
                step(mem_addr, rnd(), "lw_addr", -1, 1'b0);
                for (int i = 0; i < mw; i++) step(v(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, "lw_wait", -1, 1'b0);
                step(v(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, "lw_read", -1, 1'b0);
                step(v(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), rnd(), "lw_wb", -1, 1'b0);
            end
            6'h2B: begin
                step(mem_addr, rnd(), "sw_addr", -1, 1'b0);
                for (int i = 0; i < mw; i++) step(v(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, "sw_wait", -1, 1'b0);
                step(v(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, "sw_write", -1, 1'b0);
            end
            6'h04, 6'h05: begin
                bit take;
                take = (op == 6'h04) ? z : !z;
                step(v(0,take,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), rnd(), "branch", -1, 1'b0);
            end
            6'h08: begin
                step(mem_addr, rnd(), "addi_exec", -1, 1'b0);
                step(v(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), rnd(), "addi_wb", -1, 1'b0);
            end
            6'h02: step(v(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), rnd(), "jump", -1, 1'b0);
            default: step(v(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), rnd(), "illegal", -1, 1'b0);
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        r_l = 1'b1;
        bus.opcode = 6'h00;
        bus.funct = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_outputs", observed(), 0);
            @(posedge clock);
            #1;
        end
        r_l = 1'b0;
        @(negedge clock);
        check("reset_release_outputs", observed(), 0);
        check("reset_release_state", bus.state_dbg, S_RESET);
        @(posedge clock);
        #1;

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h23, 6'h00, 1'b0, 0, 2);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h02, 6'h00, 1'b0, 1, 0);

        bus.opcode = 6'h2B;
        bus.zero = 1'b0;
        step(v(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, "rst_sw_fetch", -1, 1'b1);
        step(v(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b0, "rst_sw_decode", -1, 1'b0);
        step(v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b0, "rst_sw_addr", -1, 1'b0);
        step(v(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, "rst_sw_wait", -1, 1'b0);
        r_l = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clock);
        check("rst_memwrite_drop", bus.MemWrite, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_mid_outputs", observed(), 0);
        check("rst_mid_state", bus.state_dbg, S_RESET);
        @(posedge clock);
        #1;
        r_l = 1'b0;
        @(negedge clock);
        check("rst_mid_release_state", bus.state_dbg, S_RESET);
        @(posedge clock);
        #1;

        for (int n = 0; n < 80; n++) begin
            int k;
            k = int'($urandom_range(0, 7));
            if (k < 7) op = ops[k];
            else begin
                op = 6'($urandom_range(0, 63));
                while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                       op == 6'h05 || op == 6'h08 || op == 6'h02)
                    op = 6'($urandom_range(0, 63));
            end
            run_instr(op, fns[$urandom_range(0, 5)], rnd(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        step(v(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, "final_fetch", -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
